// File: rtl/sha256_round_controller_if.sv
// Handshake and datapath-control bundle for the SHA-256 round controller.
// The controller takes the slave modport; source, consumer and datapath take master.
interface sha256_round_controller_if #(
    parameter int unsigned BLK_W = 16
);
    logic             block_valid;
    logic             block_last;
    logic             block_ready;
    logic             abort;
    logic             init_digest;
    logic             init_round;
    logic             partial_rounds;
    logic             update_digest;
    logic             first_block;
    logic [5:0]       round_idx;
    logic             w_sel;
    logic             busy;
    logic             digest_valid;
    logic             digest_ready;
    logic [BLK_W-1:0] blk_cnt;

    modport slave (
        input  block_valid, block_last, abort, digest_ready,
        output block_ready, init_digest, init_round, partial_rounds, update_digest,
               first_block, round_idx, w_sel, busy, digest_valid, blk_cnt
    );

    modport master (
        output block_valid, block_last, abort, digest_ready,
        input  block_ready, init_digest, init_round, partial_rounds, update_digest,
               first_block, round_idx, w_sel, busy, digest_valid, blk_cnt
    );
endinterface

// File: rtl/sha256_round_controller.sv
// Sequences the SHA-256 compression datapath over a multi-block message.
// Every output is registered and set for the state being entered.
module sha256_round_controller #(
    parameter int unsigned NUM_ROUNDS = 64,
    parameter int unsigned MSG_WORDS  = 16,
    parameter int unsigned BLK_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    sha256_round_controller_if.slave      ctl
);
    typedef enum logic [2:0] {StIdle, StInit, StRound, StUpdate, StNext, StDone} state_e;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);
    localparam logic [5:0] MSG_IDX  = 6'(MSG_WORDS);

    state_e state_q;
    logic   last_q;
    logic   flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= StIdle;
            last_q             <= 1'b0;
            flag_q             <= 1'b1;
            ctl.block_ready    <= 1'b1;
            ctl.init_digest    <= 1'b0;
            ctl.init_round     <= 1'b0;
            ctl.partial_rounds <= 1'b0;
            ctl.update_digest  <= 1'b0;
            ctl.first_block    <= 1'b0;
            ctl.round_idx      <= '0;
            ctl.w_sel          <= 1'b0;
            ctl.busy           <= 1'b0;
            ctl.digest_valid   <= 1'b0;
            ctl.blk_cnt        <= '0;
        end else begin
            // Datapath strobes are single-cycle unless re-asserted below.
            ctl.init_digest    <= 1'b0;
            ctl.init_round     <= 1'b0;
            ctl.partial_rounds <= 1'b0;
            ctl.update_digest  <= 1'b0;
            ctl.first_block    <= 1'b0;

            if (ctl.abort) begin
                state_q          <= StIdle;
                flag_q           <= 1'b1;
                ctl.block_ready  <= 1'b1;
                ctl.round_idx    <= '0;
                ctl.w_sel        <= 1'b0;
                ctl.busy         <= 1'b0;
                ctl.digest_valid <= 1'b0;
                ctl.blk_cnt      <= '0;
            end else begin
                unique case (state_q)
                    StIdle, StNext: begin
                        if (ctl.block_valid) begin
                            state_q          <= StInit;
                            last_q           <= ctl.block_last;
                            ctl.block_ready  <= 1'b0;
                            ctl.busy         <= 1'b1;
                            ctl.init_digest  <= 1'b1;
                            ctl.init_round   <= 1'b1;
                            ctl.first_block  <= (state_q == StIdle) || flag_q;
                            ctl.round_idx    <= '0;
                            ctl.w_sel        <= 1'b0;
                        end
                    end
                    StInit: begin
                        state_q            <= StRound;
                        ctl.partial_rounds <= 1'b1;
                        ctl.round_idx      <= '0;
                        ctl.w_sel          <= (MSG_IDX == 6'd0);
                    end
                    StRound: begin
                        if (ctl.round_idx == LAST_IDX) begin
                            state_q           <= StUpdate;
                            ctl.update_digest <= 1'b1;
                            ctl.round_idx     <= '0;
                            ctl.w_sel         <= 1'b0;
                        end else begin
                            ctl.partial_rounds <= 1'b1;
                            ctl.round_idx      <= ctl.round_idx + 6'd1;
                            ctl.w_sel          <= (ctl.round_idx + 6'd1) >= MSG_IDX;
                        end
                    end
                    StUpdate: begin
                        flag_q   <= 1'b0;
                        ctl.busy <= 1'b0;
                        if (!(&ctl.blk_cnt)) begin
                            ctl.blk_cnt <= ctl.blk_cnt + BLK_W'(1);
                        end
                        if (last_q) begin
                            state_q          <= StDone;
                            ctl.digest_valid <= 1'b1;
                        end else begin
                            state_q         <= StNext;
                            ctl.block_ready <= 1'b1;
                        end
                    end
                    StDone: begin
                        if (ctl.digest_ready) begin
                            state_q          <= StIdle;
                            flag_q           <= 1'b1;
                            ctl.digest_valid <= 1'b0;
                            ctl.block_ready  <= 1'b1;
                            ctl.blk_cnt      <= '0;
                        end
                    end
                    default: begin
                        state_q         <= StIdle;
                        ctl.block_ready <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
